sonar_ranger: RTL

SONAR_RANGER -- requirements
Module: sonar_ranger

---
 rtl/sonar_pkg.sv | 29 ++
 rtl/echo_sync.sv | 22 ++
 rtl/sonar_ranger.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// Shared types and zone codes for the multi-channel ultrasonic ranger.
// Pure declarations: no latency, no flow control.
package sonar_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_HOLDOFF
   } state_t;

   localparam logic [1:0] ZONE_NONE = 2'd0;
   localparam logic [1:0] ZONE_FAR  = 2'd1;
   localparam logic [1:0] ZONE_MID  = 2'd2;
   localparam logic [1:0] ZONE_NEAR = 2'd3;

   // A width equal to a threshold lands in the farther zone.
   function automatic logic [1:0] zone_code(input int unsigned width,
                                            input int unsigned near,
                                            input int unsigned mid,
                                            input int unsigned far);
      if (width < near)     return ZONE_NEAR;
      else if (width < mid) return ZONE_MID;
      else if (width < far) return ZONE_FAR;
      else                  return ZONE_NONE;
   endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for one raw echo line.
// Latency 2 clk cycles; free-running, no backpressure.
module echo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/sonar_ranger.sv
// Round-robin ultrasonic ranger: trigger, time the echo, classify into zones.
// Result strobe one cycle after echo fall or timeout; en only gates the start of a ping.
module sonar_ranger
   import sonar_pkg::*;
#(
   parameter int N_CH        = 3,
   parameter int CNT_W       = 20,
   parameter int TRIG_CYC    = 500,
   parameter int TIMEOUT_CYC = 1000000,
   parameter int HOLDOFF_CYC = 500000,
   parameter int NEAR_CYC    = 20000,
   parameter int MID_CYC     = 45000,
   parameter int FAR_CYC     = 70000
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   en,
   input  logic [N_CH-1:0]                        echo,
   output logic [N_CH-1:0]                        trig,
   output logic                                   dist_valid,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] dist_ch,
   output logic [CNT_W-1:0]                       dist_data,
   output logic                                   dist_timeout,
   output logic [2*N_CH-1:0]                      zone
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYC - 1);
   localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(N_CH - 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CH_W-1:0]   cur, cur_nxt;
   logic [N_CH-1:0]   echo_s;
   logic              echo_cur;
   logic              echo_prev;
   logic              res_fire;
   logic [CNT_W-1:0]  res_data;
   logic              res_timeout;

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      echo_sync u_sync (
         .clk  (clk),
         .rst_n(rst_n),
         .din  (echo[g]),
         .dout (echo_s[g])
      );
   end

   always_comb begin
      echo_cur = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (cur == CH_W'(k)) echo_cur = echo_s[k];
      end
   end

   // Decoded straight from the state flop so reset clears it without a clock edge.
   always_comb begin
      trig = '0;
      if (state == S_TRIG) begin
         for (int k = 0; k < N_CH; k++) begin
            if (cur == CH_W'(k)) trig[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      cur_nxt     = cur;
      res_fire    = 1'b0;
      res_data    = '0;
      res_timeout = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_nxt = S_TRIG;
               cnt_nxt   = '0;
            end
         end
         S_TRIG: begin
            if (cnt == TRIG_LAST) begin
               state_nxt = S_WAIT_RISE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_WAIT_RISE: begin
            // echo_prev tracks the channel through TRIG, so a level already high is not an edge.
            if (echo_cur && !echo_prev) begin
               state_nxt = S_MEASURE;
               cnt_nxt   = CNT_W'(1);
            end else if (cnt == TIMEOUT_LAST) begin
               res_fire    = 1'b1;
               res_timeout = 1'b1;
               state_nxt   = S_HOLDOFF;
               cnt_nxt     = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_MEASURE: begin
            if (cnt == TIMEOUT_MAX) begin
               res_fire    = 1'b1;
               res_data    = cnt;
               res_timeout = 1'b1;
               state_nxt   = S_HOLDOFF;
               cnt_nxt     = '0;
            end else if (!echo_cur) begin
               res_fire  = 1'b1;
               res_data  = cnt;
               state_nxt = S_HOLDOFF;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_HOLDOFF: begin
            if (cnt == HOLD_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               cur_nxt   = (cur == CH_LAST) ? '0 : cur + CH_W'(1);
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt          <= '0;
         cur          <= '0;
         echo_prev    <= 1'b0;
         dist_valid   <= 1'b0;
         dist_ch      <= '0;
         dist_data    <= '0;
         dist_timeout <= 1'b0;
         zone         <= '0;
      end else begin
         cnt        <= cnt_nxt;
         cur        <= cur_nxt;
         echo_prev  <= echo_cur;
         dist_valid <= res_fire;
         if (res_fire) begin
            dist_ch      <= cur;
            dist_data    <= res_data;
            dist_timeout <= res_timeout;
            for (int k = 0; k < N_CH; k++) begin
               if (cur == CH_W'(k)) begin
                  zone[2*k +: 2] <= res_timeout ? ZONE_NONE :
                     zone_code(32'(res_data), NEAR_CYC, MID_CYC, FAR_CYC);
               end
            end
         end
      end
   end

endmodule
